// File: rtl/nanov_periph_ctrl_pkg.sv
// Shared definitions for the nanoV peripheral controller.
// Holds the register offsets, the one-hot select encoding, the TX FSM states,
// the status bit positions and the address decode helper.
package nanov_periph_ctrl_pkg;

  localparam logic [31:0] OFF_GPIO = 32'h0000_0000;
  localparam logic [31:0] OFF_UART = 32'h0000_0010;
  localparam logic [31:0] OFF_STAT = 32'h0000_0014;
  localparam logic [31:0] OFF_LVL  = 32'h0000_0018;

  typedef enum logic [3:0] {
    SEL_NONE = 4'b0000,
    SEL_GPIO = 4'b0001,
    SEL_UART = 4'b0010,
    SEL_STAT = 4'b0100,
    SEL_LVL  = 4'b1000
  } sel_e;

  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_START   = 2'd1,
    TX_WAIT_HI = 2'd2,
    TX_DRAIN   = 2'd3
  } tx_state_e;

  localparam int STAT_TX_FULL  = 0;
  localparam int STAT_RX_VALID = 1;
  localparam int STAT_TX_IDLE  = 2;
  localparam int STAT_OVERFLOW = 3;

  // Exact word compare against each register address; anything else selects nothing.
  function automatic sel_e decode_sel(input logic [31:0] addr, input logic [31:0] base);
    sel_e s;
    s = SEL_NONE;
    if (addr == base + OFF_GPIO)      s = SEL_GPIO;
    else if (addr == base + OFF_UART) s = SEL_UART;
    else if (addr == base + OFF_STAT) s = SEL_STAT;
    else if (addr == base + OFF_LVL)  s = SEL_LVL;
    return s;
  endfunction

endpackage

// File: rtl/nanov_periph_ctrl_fifo.sv
// Synchronous FIFO with first-word-fall-through head.
// Ports: push_i/wdata_i write side, pop_i/rdata_o read side (rdata_o is the
// current head), full_o/empty_o flags, level_o occupancy 0..DEPTH.
// Pointers carry one extra wrap bit so full and empty are told apart by compare.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module nanov_periph_ctrl_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible once written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/nanov_periph_ctrl.sv
// nanoV memory-mapped peripheral controller.
// Ports: clk/rstn; CPU bus strobes is_addr, is_data (write), is_data_in (read),
// bus_addr, wdata, rdata; buttons in, led_data out; uart_tx_en/uart_tx_data/
// uart_tx_busy toward uart_tx; uart_rx_valid/uart_rx_data/uart_rx_read toward
// uart_rx; tx_state_dbg exposes the TX FSM state.
//
// Handshakes: every CPU strobe is a single-cycle qualifier acting on the select
// registered by the last is_addr; there is no back-pressure to the CPU.
// uart_rx_read is the acknowledge for uart_rx_valid, asserted in the read cycle.
// Toward uart_tx, uart_tx_en is a one-cycle start with uart_tx_data stable; the
// transmitter answers with uart_tx_busy, and a new start is only issued once
// uart_tx_busy is low again (or never rose within two cycles).
module nanov_periph_ctrl
  import nanov_periph_ctrl_pkg::*;
#(
  parameter int          TX_DEPTH  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        is_addr,
  input  logic        is_data,
  input  logic        is_data_in,
  input  logic [31:0] bus_addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [2:0]  buttons,
  output logic [31:0] led_data,
  output logic        uart_tx_en,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_tx_busy,
  input  logic        uart_rx_valid,
  input  logic [7:0]  uart_rx_data,
  output logic        uart_rx_read,
  output tx_state_e   tx_state_dbg
);

  localparam int LW = $clog2(TX_DEPTH) + 1;

  sel_e        sel_q, sel_d;
  logic [31:0] led_q, led_d;
  logic        ovf_q, ovf_d;
  tx_state_e   state_q, state_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        wait_q, wait_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_head;
  logic [LW-1:0] fifo_level;
  logic          tx_idle;
  logic [31:0]   stat_word;

  assign fifo_push = is_data & (sel_q == SEL_UART);

  nanov_periph_ctrl_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (fifo_push),
    .wdata_i (wdata[7:0]),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Decode, GPIO write and sticky overflow.
  always_comb begin
    sel_d = is_addr ? decode_sel(bus_addr, BASE_ADDR) : sel_q;
    led_d = led_q;
    ovf_d = ovf_q;
    if (is_data && sel_q == SEL_GPIO) led_d = wdata;
    if (is_data_in && sel_q == SEL_STAT) ovf_d = 1'b0;
    // A push into a full FIFO is only a drop when no pop frees a slot; set beats clear.
    if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
  end

  // TX sequencer.
  always_comb begin
    state_d   = state_q;
    tx_byte_d = tx_byte_q;
    wait_d    = wait_q;
    fifo_pop  = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        if (!fifo_empty && !uart_tx_busy) begin
          fifo_pop  = 1'b1;
          tx_byte_d = fifo_head;
          state_d   = TX_START;
        end
      end
      TX_START: begin
        wait_d  = 1'b0;
        state_d = TX_WAIT_HI;
      end
      TX_WAIT_HI: begin
        // Give the transmitter two cycles to raise busy before giving up on it.
        if (uart_tx_busy)  state_d = TX_DRAIN;
        else if (wait_q)   state_d = TX_IDLE;
        else               wait_d  = 1'b1;
      end
      TX_DRAIN: begin
        if (!uart_tx_busy) state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel_q     <= SEL_NONE;
      led_q     <= '0;
      ovf_q     <= 1'b0;
      state_q   <= TX_IDLE;
      tx_byte_q <= '0;
      wait_q    <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      led_q     <= led_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      tx_byte_q <= tx_byte_d;
      wait_q    <= wait_d;
    end
  end

  assign tx_idle = fifo_empty & (state_q == TX_IDLE) & ~uart_tx_busy;

  always_comb begin
    stat_word                = '0;
    stat_word[STAT_TX_FULL]  = fifo_full;
    stat_word[STAT_RX_VALID] = uart_rx_valid;
    stat_word[STAT_TX_IDLE]  = tx_idle;
    stat_word[STAT_OVERFLOW] = ovf_q;
  end

  always_comb begin
    rdata = '0;
    unique case (sel_q)
      SEL_GPIO: rdata = {29'b0, buttons};
      SEL_UART: rdata = {24'b0, uart_rx_data};
      SEL_STAT: rdata = stat_word;
      SEL_LVL:  rdata = {{(32-LW){1'b0}}, fifo_level};
      default:  rdata = '0;
    endcase
  end

  assign led_data     = led_q;
  assign uart_tx_en   = (state_q == TX_START);
  assign uart_tx_data = tx_byte_q;
  assign uart_rx_read = is_data_in & (sel_q == SEL_UART);
  assign tx_state_dbg = state_q;

endmodule

// File: tb/tb_nanov_periph_ctrl.sv
module tb_nanov_periph_ctrl;
  import nanov_periph_ctrl_pkg::*;

  localparam logic [31:0] BASE = 32'h1000_0000;

  // Clock / reset
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        is_addr, is_data, is_data_in;
  logic [31:0] bus_addr, wdata, rdata, led_data;
  logic [2:0]  buttons;
  logic        uart_tx_en, uart_tx_busy, uart_rx_valid, uart_rx_read;
  logic [7:0]  uart_tx_data, uart_rx_data;
  tx_state_e   tx_state_dbg;

  nanov_periph_ctrl #(.TX_DEPTH(8), .BASE_ADDR(BASE)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .is_addr       (is_addr),
    .is_data       (is_data),
    .is_data_in    (is_data_in),
    .bus_addr      (bus_addr),
    .wdata         (wdata),
    .rdata         (rdata),
    .buttons       (buttons),
    .led_data      (led_data),
    .uart_tx_en    (uart_tx_en),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_busy  (uart_tx_busy),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_read  (uart_rx_read),
    .tx_state_dbg  (tx_state_dbg)
  );

  // uart_tx model: busy for 10 cycles after each start, or forced level.
  logic model_en, busy_force;
  int   busy_cnt;
  assign uart_tx_busy = model_en ? (busy_cnt != 0) : busy_force;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) busy_cnt <= 0;
    else if (uart_tx_en) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  // Scoreboard: expected bytes and captured transmits.
  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];
  always @(posedge clk) begin
    if (rstn && uart_tx_en) cap_q.push_back(uart_tx_data);
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks: all start and end on a negedge.
  task automatic set_sel(input logic [31:0] a);
    is_addr = 1'b1; bus_addr = a;
    @(negedge clk);
    is_addr = 1'b0;
  endtask

  task automatic wr_cur(input logic [31:0] d);
    is_data = 1'b1; wdata = d;
    @(negedge clk);
    is_data = 1'b0;
  endtask

  task automatic rd_cur(output logic [31:0] r);
    is_data_in = 1'b1;
    #1 r = rdata;
    @(negedge clk);
    is_data_in = 1'b0;
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    set_sel(a);
    wr_cur(d);
  endtask

  task automatic rd_reg(input logic [31:0] a, output logic [31:0] r);
    set_sel(a);
    rd_cur(r);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int n;
    rstn = 1'b0; is_addr = 0; is_data = 0; is_data_in = 0;
    bus_addr = '0; wdata = '0; buttons = 3'b000;
    uart_rx_valid = 0; uart_rx_data = '0;
    model_en = 0; busy_force = 0;
    repeat (3) @(negedge clk);
    check("rst_led", led_data, 32'h0);
    check("rst_tx_en", {31'b0, uart_tx_en}, 32'h0);
    check("rst_state", 32'(tx_state_dbg), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    rstn = 1'b1;
    @(negedge clk);

    // Decode and GPIO
    wr_reg(BASE, 32'hA5);
    check("gpio_write", led_data, 32'hA5);
    wr_reg(BASE + 32'h4, 32'hFFFF_0000);
    check("unmapped_write", led_data, 32'hA5);
    rd_reg(BASE + 32'h4, r);
    check("unmapped_read", r, 32'h0);
    buttons = 3'b101;
    rd_reg(BASE, r);
    check("gpio_read", r, 32'h5);

    // RX read
    uart_rx_valid = 1'b1; uart_rx_data = 8'h5A;
    set_sel(BASE + 32'h10);
    is_data_in = 1'b1;
    #1;
    check("rx_data", rdata, 32'h5A);
    check("rx_read_hi", {31'b0, uart_rx_read}, 32'h1);
    @(negedge clk);
    is_data_in = 1'b0;
    #1;
    check("rx_read_lo", {31'b0, uart_rx_read}, 32'h0);
    rd_reg(BASE + 32'h14, r);
    check("stat_rx_idle", r, 32'h6);
    uart_rx_valid = 1'b0;

    // Burst of 8 with transmitter model
    busy_force = 1'b1;
    set_sel(BASE + 32'h10);
    for (int i = 0; i < 8; i++) begin
      wr_cur(32'h41 + i);
      exp_q.push_back(8'(8'h41 + i));
    end
    rd_reg(BASE + 32'h18, r);
    check("burst_level", r, 32'h8);
    rd_reg(BASE + 32'h14, r);
    check("burst_stat_full", r, 32'h1);
    cap_q.delete();
    model_en = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (cap_q.size() == 8 && tx_state_dbg == TX_IDLE && !uart_tx_busy) break;
    end
    check("burst_count", cap_q.size(), 32'd8);
    n = cap_q.size();
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() != 0) check("burst_byte", {24'b0, cap_q[i]}, {24'b0, exp_q.pop_front()});
    end
    rd_reg(BASE + 32'h14, r);
    check("burst_stat_idle", r, 32'h4);
    model_en = 1'b0;

    // Overflow: 9 writes with busy held
    busy_force = 1'b1;
    set_sel(BASE + 32'h10);
    for (int i = 0; i < 9; i++) wr_cur(32'h61 + i);
    rd_reg(BASE + 32'h18, r);
    check("ovf_level", r, 32'h8);
    set_sel(BASE + 32'h14);
    rd_cur(r);
    check("ovf_stat", r, 32'h9);
    rd_cur(r);
    check("ovf_cleared", r, 32'h1);

    // Full FIFO: push in the same cycle busy falls and a pop occurs
    set_sel(BASE + 32'h10);
    is_data = 1'b1; wdata = 32'h99; busy_force = 1'b0;
    @(negedge clk);
    is_data = 1'b0; busy_force = 1'b1;
    #1;
    check("fpp_tx_en", {31'b0, uart_tx_en}, 32'h1);
    check("fpp_head", {24'b0, uart_tx_data}, 32'h61);
    @(negedge clk);
    rd_reg(BASE + 32'h18, r);
    check("fpp_level", r, 32'h8);
    rd_reg(BASE + 32'h14, r);
    check("fpp_stat", r, 32'h1);

    // Reset while in START with 3 queued
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    wr_reg(BASE, 32'h1234);
    busy_force = 1'b1;
    set_sel(BASE + 32'h10);
    for (int i = 0; i < 4; i++) wr_cur(32'h71 + i);
    set_sel(BASE + 32'h18);
    busy_force = 1'b0;
    @(negedge clk);
    #1;
    check("pre_rst_state", 32'(tx_state_dbg), 32'(TX_START));
    check("pre_rst_level", rdata, 32'h3);
    rstn = 1'b0;
    #1;
    check("mid_rst_led", led_data, 32'h0);
    check("mid_rst_tx_en", {31'b0, uart_tx_en}, 32'h0);
    check("mid_rst_state", 32'(tx_state_dbg), 32'(TX_IDLE));
    @(negedge clk);
    rstn = 1'b1;
    cap_q.delete();
    repeat (30) @(negedge clk);
    check("post_rst_no_tx", cap_q.size(), 32'd0);
    rd_reg(BASE + 32'h18, r);
    check("post_rst_level", r, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
